// File: rtl/euler_pkg.sv
// euler_pkg: shared widths and FSM encoding for the euler1 solver and its result path
package euler_pkg;
  localparam int EULER_RESULT_W   = 24;
  localparam int EULER_BCD_DIGITS = 8;
  typedef enum logic [1:0] {IDLE, CONV, STREAM} state_e;
endpackage

// File: rtl/euler_bcd_adjust.sv
// euler_bcd_adjust: double-dabble add-3 correction applied independently to every BCD digit
module euler_bcd_adjust #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] d_i,
  output logic [4*DIGITS-1:0] d_o
);
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign d_o[4*g +: 4] = (d_i[4*g +: 4] >= 4'd5) ? d_i[4*g +: 4] + 4'd3 : d_i[4*g +: 4];
  end
endmodule

// File: rtl/euler_result_bcd.sv
// euler_result_bcd: converts the solver result to packed BCD and streams its significant digits MSD-first
module euler_result_bcd
  import euler_pkg::*;
#(
  parameter int IN_WIDTH = EULER_RESULT_W,
  parameter int DIGITS   = EULER_BCD_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic [3:0]          num_digits,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic                digit_last
);
  localparam int BW = 4*DIGITS;
  localparam int AW = BW + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  state_e        state_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] bcd_q, adj_d;
  logic [3:0]    nd_q, nd_d;
  logic          busy_q, bcd_valid_q, dv_q;
  euler_bcd_adjust #(.DIGITS(DIGITS)) u_adj (.d_i(acc_q[AW-1:IN_WIDTH]), .d_o(adj_d));
  assign acc_d = {adj_d, acc_q[IN_WIDTH-1:0]} << 1;
  always_comb begin
    nd_d = 4'd1;
    for (int i = 1; i < DIGITS; i++)
      if (acc_q[IN_WIDTH + 4*i +: 4] != 4'd0) nd_d = 4'(i + 1);
  end
  // cnt_q counts remaining shifts; the cycle after it reaches zero publishes the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      bcd_q       <= '0;
      nd_q        <= '0;
      busy_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          acc_q   <= {{BW{1'b0}}, in_data};
          cnt_q   <= CW'(IN_WIDTH);
          busy_q  <= 1'b1;
          state_q <= CONV;
        end
        CONV: if (cnt_q != '0) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
        end else begin
          bcd_q       <= acc_q[AW-1:IN_WIDTH];
          nd_q        <= nd_d;
          idx_q       <= IW'(nd_d - 4'd1);
          bcd_valid_q <= 1'b1;
          dv_q        <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: if (digit_ready) begin
          if (idx_q == '0) begin
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else idx_q <= idx_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy        = busy_q;
  assign bcd         = bcd_q;
  assign bcd_valid   = bcd_valid_q;
  assign num_digits  = nd_q;
  assign digit_valid = dv_q;
  assign digit_out   = 4'(bcd_q >> {idx_q, 2'b00});
  assign digit_last  = dv_q && (idx_q == '0);
endmodule

// File: tb/tb_euler_result_bcd.sv
// tb_euler_result_bcd: scoreboard bench for conversion latency, digit streaming, backpressure, ignore and abort
module tb_euler_result_bcd;
  logic        clk = 1'b0;
  logic        reset, in_valid, busy, bcd_valid, digit_valid, digit_ready, digit_last;
  logic [23:0] in_data;
  logic [31:0] bcd;
  logic [3:0]  num_digits, digit_out;
  int checks = 0, errors = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] bcd_sb[$];
  logic [3:0]  nd_sb[$];

  euler_result_bcd dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .busy(busy),
    .bcd(bcd), .bcd_valid(bcd_valid), .num_digits(num_digits), .digit_out(digit_out),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .digit_last(digit_last)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if ({busy, bcd, bcd_valid, num_digits, digit_out, digit_valid, digit_last} !== 43'd0) begin
      errors++;
      $display("FAIL %s: busy=%b bcd=%h bv=%b nd=%0d d=%0d dv=%b dl=%b required all zero",
               nm, busy, bcd, bcd_valid, num_digits, digit_out, digit_valid, digit_last);
    end
  endtask

  task automatic send(input int v);
    logic [31:0] b;
    int t, n;
    b = '0; t = v; n = 1;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    for (int i = 1; i < 8; i++) if (b[4*i +: 4] != 4'd0) n = i + 1;
    bcd_sb.push_back(b);
    nd_sb.push_back(4'(n));
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(b[4*i +: 4]);
    in_data = 24'(v);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_bcd(input int lat, input string nm);
    int k;
    logic [31:0] eb;
    logic [3:0] en;
    k = 0;
    while (!bcd_valid && k < 40) begin
      tick;
      k++;
    end
    checks++;
    if (k != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", nm, k, lat);
    end
    if (bcd_valid && bcd_sb.size() > 0) begin
      eb = bcd_sb.pop_front();
      en = nd_sb.pop_front();
      checks++;
      if (bcd !== eb || num_digits !== en || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s result: bcd=%h nd=%0d busy=%b, required bcd=%h nd=%0d busy=1",
                 nm, bcd, num_digits, busy, eb, en);
      end
    end
  endtask

  task automatic drain(input int hold_at, input int hold_len, input string nm);
    int got, held, cyc;
    logic [3:0] e;
    got = 0; held = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      digit_ready = !(got == hold_at && held < hold_len);
      checks++;
      if (digit_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s valid: digit_valid=%b at digit %0d, required 1", nm, digit_valid, got);
        break;
      end else if (digit_ready) begin
        e = exp_q.pop_front();
        if (digit_out !== e || digit_last !== (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL %s digit %0d: got %0d last=%b, required %0d last=%b",
                   nm, got, digit_out, digit_last, e, exp_q.size() == 0);
        end
        got++;
      end else begin
        if (digit_out !== exp_q[0] || digit_last !== (exp_q.size() == 1)) begin
          errors++;
          $display("FAIL %s hold: got %0d last=%b, required %0d last=%b",
                   nm, digit_out, digit_last, exp_q[0], exp_q.size() == 1);
        end
        held++;
      end
      tick;
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (bcd_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s pulse: bcd_valid=%b one cycle later, required 0", nm, bcd_valid);
        end
      end
    end
    digit_ready = 1'b1;
    checks++;
    if (digit_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s end: dv=%b busy=%b left=%0d, required 0 0 0", nm, digit_valid, busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_data = 24'd55; digit_ready = 1'b1;
    tick;
    tick;
    check_idle("reset");
    reset = 1'b0; in_valid = 1'b0;
    tick;
    check_idle("reset_release");
  endtask

  task automatic test_basic;
    send(233168);
    wait_bcd(25, "basic");
    drain(-1, 0, "basic");
  endtask

  task automatic test_zero;
    send(0);
    wait_bcd(25, "zero");
    drain(-1, 0, "zero");
  endtask

  task automatic test_max;
    send(16777215);
    wait_bcd(25, "max");
    drain(-1, 0, "max");
  endtask

  task automatic test_backpressure;
    send(233168);
    wait_bcd(25, "bp");
    drain(1, 5, "bp");
  endtask

  task automatic test_ignore;
    send(233168);
    tick; tick; tick;
    in_data = 24'd999; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore busy: got %b, required 1", busy);
    end
    wait_bcd(20, "ignore");
    drain(-1, 0, "ignore");
    tick;
    checks++;
    if (busy !== 1'b0 || digit_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore queued: busy=%b dv=%b, required 0 0", busy, digit_valid);
    end
  endtask

  task automatic test_abort;
    send(233168);
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_q.delete(); bcd_sb.delete(); nd_sb.delete();
    check_idle("abort");
    repeat (30) tick;
    check_idle("abort_quiet");
    send(23);
    wait_bcd(25, "abort_next");
    drain(-1, 0, "abort_next");
  endtask

  task automatic test_back_to_back;
    send(5);
    wait_bcd(25, "b2b_a");
    drain(-1, 0, "b2b_a");
    send(4096);
    wait_bcd(25, "b2b_b");
    drain(-1, 0, "b2b_b");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_max;
    test_backpressure;
    test_ignore;
    test_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
